meta_chooser_ras: RTL and testbench

Chooser-and-return-stack unit for the META branch predictor. It holds two structures. The first is a 1024-entry table of 2-bit saturating counters that selects between the global and local direction predictors per PC. The second is an 8-entry return-address stack (RAS) that supplies targets for `jr $ra` in IF. It sits beside the BTB and global/local predictors; the META control logic consumes its outputs when choosing the IF redirect.

---
 rtl/meta_chooser_ras.sv | 116 +++++++++++
 tb/tb_meta_chooser_ras.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/meta_chooser_ras.sv
// meta_chooser_ras
// Chooser-and-return-stack unit for the META branch predictor. It contains:
//   - a table of 2-bit saturating counters, indexed by PC[11:2], that picks
//     the global (1) or local (0) direction predictor for each PC;
//   - a return-address stack that predicts the target of `jr $ra` in IF.
// Ports:
//   CLK, RESET         clock and asynchronous active-low reset
//   isTaken, isBranch  chooser training direction and update enable
//   InstrPC            PC of the ID-stage branch being trained
//   Pred               per-entry chooser decision (MSB of each counter)
//   InstrPC_IF         IF PC (informational only)
//   Instr_IF           fetched instruction word (return detection)
//   IsJL, InstrPC_ID   ID-stage jump-and-link indication and its PC (push)
//   hit, alt_PC        RAS return-target valid and predicted return address
module meta_chooser_ras #(
  parameter int CHOOSER_ENTRIES = 1024,
  parameter int RAS_DEPTH       = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       isTaken,
  input  logic                       isBranch,
  input  logic [31:0]                InstrPC,
  output logic [CHOOSER_ENTRIES-1:0] Pred,
  input  logic [31:0]                InstrPC_IF,
  input  logic [31:0]                Instr_IF,
  input  logic                       IsJL,
  input  logic [31:0]                InstrPC_ID,
  output logic                       hit,
  output logic [31:0]                alt_PC
);

  localparam int IW = $clog2(CHOOSER_ENTRIES);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [31:0] JR_RA = 32'h03E0_0008;

  // ---------------- chooser ----------------
  logic [1:0]    ctr_q [CHOOSER_ENTRIES];
  logic [1:0]    ctr_d;
  logic [IW-1:0] ch_idx;

  assign ch_idx = InstrPC[IW+1:2];

  always_comb begin
    ctr_d = ctr_q[ch_idx];
    if (isTaken) begin
      if (ctr_q[ch_idx] != 2'b11) ctr_d = ctr_q[ch_idx] + 2'b01;
    end else begin
      if (ctr_q[ch_idx] != 2'b00) ctr_d = ctr_q[ch_idx] - 2'b01;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < CHOOSER_ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (isBranch) begin
      ctr_q[ch_idx] <= ctr_d;
    end
  end

  always_comb begin
    Pred = '0;
    for (int unsigned i = 0; i < CHOOSER_ENTRIES; i++) Pred[i] = ctr_q[i][1];
  end

  // ---------------- return-address stack ----------------
  // ptr_q addresses the current top entry; a push pre-increments it.
  logic [31:0]   stack_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic          not_empty;

  assign not_empty = (cnt_q != '0);
  assign hit       = (Instr_IF == JR_RA) && not_empty;
  assign alt_PC    = not_empty ? stack_q[ptr_q] : '0;

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = InstrPC_ID + 32'd8;
    if (IsJL && hit) begin
      // push+pop collapses into replacing the top entry in place
      wr_en = 1'b1;
    end else if (IsJL) begin
      ptr_d  = ptr_q + PW'(1);
      wr_idx = ptr_q + PW'(1);
      wr_en  = 1'b1;
      if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (hit) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en) stack_q[wr_idx] <= wr_data;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{InstrPC_IF, InstrPC[31:IW+2], InstrPC[1:0]};

endmodule

// File: tb/tb_meta_chooser_ras.sv
module tb_meta_chooser_ras;

  localparam logic [31:0] JR = 32'h03E0_0008;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         isTaken, isBranch, IsJL;
  logic [31:0]  InstrPC, InstrPC_IF, Instr_IF, InstrPC_ID;
  logic [1023:0] Pred;
  logic         hit;
  logic [31:0]  alt_PC;

  int checks = 0;
  int errors = 0;

  meta_chooser_ras #(.CHOOSER_ENTRIES(1024), .RAS_DEPTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .isTaken(isTaken), .isBranch(isBranch),
    .InstrPC(InstrPC), .Pred(Pred), .InstrPC_IF(InstrPC_IF),
    .Instr_IF(Instr_IF), .IsJL(IsJL), .InstrPC_ID(InstrPC_ID),
    .hit(hit), .alt_PC(alt_PC)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        br;
    logic        tk;
    logic [31:0] pc;
    logic        jl;
    logic [31:0] pcid;
    logic [31:0] ifw;
    int          idx;
    logic        pred_pre;
    logic        pred_post;
    logic        hit_pre;
    logic [31:0] alt_pre;
    logic [31:0] alt_post;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic br, logic tk, logic [31:0] pc, logic jl,
                              logic [31:0] pcid, logic [31:0] ifw, int idx,
                              logic pp, logic pq, logic h,
                              logic [31:0] a0, logic [31:0] a1);
    vec_t v;
    v.br = br; v.tk = tk; v.pc = pc; v.jl = jl; v.pcid = pcid; v.ifw = ifw;
    v.idx = idx; v.pred_pre = pp; v.pred_post = pq; v.hit_pre = h;
    v.alt_pre = a0; v.alt_post = a1;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    isBranch = 0; isTaken = 0; InstrPC = '0; IsJL = 0; InstrPC_ID = '0; Instr_IF = '0;
  endtask

  initial begin
    InstrPC_IF = 32'h0000_0000;
    idle();
    RESET = 0;
    #2;
    check("rst_pred", {31'b0, |Pred}, 32'd0);
    check("rst_hit", {31'b0, hit}, 32'd0);
    check("rst_alt", alt_PC, 32'd0);
    @(negedge CLK); @(negedge CLK);
    RESET = 1;
    Instr_IF = JR;
    #1;
    check("empty_jr_hit", {31'b0, hit}, 32'd0);
    check("empty_jr_alt", alt_PC, 32'd0);

    // chooser saturation at index 4, aliasing, index 1023
    vecs.push_back(mk(1,1,32'h10,0,0,0,4, 0,1, 0,0,0));
    vecs.push_back(mk(1,1,32'h10,0,0,0,4, 1,1, 0,0,0));
    vecs.push_back(mk(1,1,32'h10,0,0,0,4, 1,1, 0,0,0));
    vecs.push_back(mk(1,1,32'h10,0,0,0,4, 1,1, 0,0,0));
    vecs.push_back(mk(1,0,32'h10,0,0,0,4, 1,1, 0,0,0));
    vecs.push_back(mk(1,0,32'h10,0,0,0,4, 1,0, 0,0,0));
    vecs.push_back(mk(1,1,32'h1010,0,0,0,4, 0,1, 0,0,0));
    vecs.push_back(mk(1,1,32'hFFC,0,0,0,1023, 0,1, 0,0,0));
    // RAS push/pop
    vecs.push_back(mk(0,0,0,1,32'h400,0,4, 1,1, 0,32'h0,32'h408));
    vecs.push_back(mk(0,0,0,1,32'h500,0,4, 1,1, 0,32'h408,32'h508));
    vecs.push_back(mk(0,0,0,0,0,JR,4, 1,1, 1,32'h508,32'h408));
    vecs.push_back(mk(0,0,0,0,0,JR,4, 1,1, 1,32'h408,32'h0));
    vecs.push_back(mk(0,0,0,0,0,JR,4, 1,1, 0,32'h0,32'h0));
    // simultaneous push+pop, non-return word
    vecs.push_back(mk(0,0,0,1,32'h400,0,4, 1,1, 0,32'h0,32'h408));
    vecs.push_back(mk(0,0,0,1,32'h700,JR,4, 1,1, 1,32'h408,32'h708));
    vecs.push_back(mk(0,0,0,0,0,32'h03E00009,4, 1,1, 0,32'h708,32'h708));
    vecs.push_back(mk(0,0,0,0,0,JR,4, 1,1, 1,32'h708,32'h0));
    vecs.push_back(mk(0,0,0,0,0,JR,4, 1,1, 0,32'h0,32'h0));
    // return address wraps modulo 2^32
    vecs.push_back(mk(0,0,0,1,32'hFFFF_FFFC,0,1023, 1,1, 0,32'h0,32'h4));
    vecs.push_back(mk(0,0,0,0,0,JR,1023, 1,1, 1,32'h4,32'h0));

    foreach (vecs[n]) begin
      @(negedge CLK);
      isBranch = vecs[n].br; isTaken = vecs[n].tk; InstrPC = vecs[n].pc;
      IsJL = vecs[n].jl; InstrPC_ID = vecs[n].pcid; Instr_IF = vecs[n].ifw;
      #1;
      check($sformatf("v%0d pred_pre", n), {31'b0, Pred[vecs[n].idx]}, {31'b0, vecs[n].pred_pre});
      check($sformatf("v%0d hit", n), {31'b0, hit}, {31'b0, vecs[n].hit_pre});
      check($sformatf("v%0d alt_pre", n), alt_PC, vecs[n].alt_pre);
      @(posedge CLK);
      #1;
      check($sformatf("v%0d pred_post", n), {31'b0, Pred[vecs[n].idx]}, {31'b0, vecs[n].pred_post});
      check($sformatf("v%0d alt_post", n), alt_PC, vecs[n].alt_post);
    end

    // update disabled: 10 cycles with isTaken=1 on an entry currently at 2'b10
    @(negedge CLK);
    idle();
    InstrPC = 32'h10; isTaken = 1;
    repeat (10) @(posedge CLK);
    #1;
    check("noen_pred4", {31'b0, Pred[4]}, 32'd1);
    // one decrement: 10->01 proves the counter did not move above 2'b10
    @(negedge CLK);
    isBranch = 1; isTaken = 0;
    @(posedge CLK); #1;
    check("noen_dec_pred4", {31'b0, Pred[4]}, 32'd0);
    check("other_idx1023", {31'b0, Pred[1023]}, 32'd1);
    check("other_idx5", {31'b0, Pred[5]}, 32'd0);

    // overflow: 9 pushes into an 8-deep stack, then 8 pops
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      idle();
      IsJL = 1; InstrPC_ID = k * 32'h100;
    end
    @(negedge CLK);
    idle();
    for (int k = 9; k >= 2; k--) begin
      Instr_IF = JR;
      #1;
      check($sformatf("ovf_hit%0d", k), {31'b0, hit}, 32'd1);
      check($sformatf("ovf_alt%0d", k), alt_PC, k * 32'h100 + 32'h8);
      @(negedge CLK);
    end
    Instr_IF = JR;
    #1;
    check("ovf_empty_hit", {31'b0, hit}, 32'd0);

    // asynchronous reset mid-operation
    @(negedge CLK);
    idle();
    IsJL = 1; InstrPC_ID = 32'h300; isBranch = 1; isTaken = 1; InstrPC = 32'h20;
    @(negedge CLK);
    idle();
    Instr_IF = JR;
    #1;
    check("pre_rst_alt", alt_PC, 32'h308);
    check("pre_rst_pred8", {31'b0, Pred[8]}, 32'd1);
    #1 RESET = 0;
    #1;
    check("arst_alt", alt_PC, 32'h0);
    check("arst_hit", {31'b0, hit}, 32'd0);
    check("arst_pred", {31'b0, |Pred}, 32'd0);
    @(negedge CLK);
    RESET = 1;
    Instr_IF = '0; IsJL = 1; InstrPC_ID = 32'h600;
    @(posedge CLK); #1;
    check("post_rst_push", alt_PC, 32'h608);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
